// File: rtl/up_pkg.sv
// up_pkg: shared state encoding, error codes and sizing for the up_core boot sequencer
package up_pkg;

    localparam int MEM_DEPTH   = 256;
    localparam int HOLD_CYCLES = 16;
    localparam int TIMEOUT     = 4096;
    localparam int INT_LOW     = 4;

    typedef enum logic [2:0] {IDLE, HOLD, LOAD, CHECK, RUN} state_e;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_CSUM    = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

endpackage

// File: rtl/up_tick_gen.sv
// up_tick_gen: periodic tick counter shaping an active-low interrupt pulse of INT_LOW cycles
module up_tick_gen
    import up_pkg::*;
(
    input  logic        clk_i,
    input  logic        nrst_i,
    input  logic        en_i,
    input  logic [15:0] period_i,
    output logic        int_o
);

    logic [15:0] cnt_q, cnt_d, per;
    logic        int_q, int_d;

    // clamp the period so the low pulse always has at least one high cycle after it
    always_comb begin
        per   = (period_i < 16'(INT_LOW + 1)) ? 16'(INT_LOW + 1) : period_i;
        cnt_d = (!en_i || cnt_q >= per - 16'd1) ? '0 : cnt_q + 16'd1;
        int_d = !(en_i && cnt_q < 16'(INT_LOW));
    end

    // counter and registered interrupt; disabling returns both to idle
    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            cnt_q <= '0;
            int_q <= 1'b1;
        end else begin
            cnt_q <= cnt_d;
            int_q <= int_d;
        end
    end

    assign int_o = int_q;

endmodule

// File: rtl/up_boot_ctrl.sv
// up_boot_ctrl: holds up_core in reset, streams its image into memory, verifies checksum, then runs it
module up_boot_ctrl
    import up_pkg::*;
(
    input  logic        clk_i,
    input  logic        nrst_i,
    input  logic        load_start_i,
    input  logic        rx_valid_i,
    input  logic [7:0]  rx_data_i,
    output logic        rx_ready_o,
    output logic        core_nrst_o,
    output logic        mem_we_o,
    output logic [7:0]  mem_addr_o,
    output logic [7:0]  mem_wdata_o,
    input  logic        tick_en_i,
    input  logic [15:0] tick_period_i,
    output logic        int_o,
    output logic        busy_o,
    output logic        done_o,
    output logic [1:0]  err_o
);

    state_e      state_q, state_d;
    logic [8:0]  cnt_q, cnt_d;
    logic [12:0] tmr_q, tmr_d;
    logic [7:0]  sum_q, sum_d;
    logic [1:0]  err_q, err_d;
    logic        rx_ready_q, rx_ready_d;
    logic        core_nrst_q, core_nrst_d;
    logic        mem_we_q, mem_we_d;
    logic [7:0]  mem_addr_q, mem_addr_d;
    logic [7:0]  mem_wdata_q, mem_wdata_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        accept, restart;

    assign accept  = rx_valid_i && rx_ready_q;
    assign restart = load_start_i && (state_q == IDLE || state_q == RUN);

    // state register
    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // next-state: the byte after the last image byte is the checksum and ends the load
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (load_start_i) state_d = HOLD;
            HOLD:    if (tmr_q == 13'(HOLD_CYCLES - 1)) state_d = LOAD;
            LOAD:    if (accept && cnt_q == 9'(MEM_DEPTH)) state_d = CHECK;
                     else if (!accept && tmr_q == 13'(TIMEOUT - 1)) state_d = IDLE;
            CHECK:   state_d = (sum_q == 8'd0) ? RUN : IDLE;
            RUN:     if (load_start_i) state_d = HOLD;
            default: state_d = IDLE;
        endcase
    end

    // outputs and datapath derived from the next state so every output is a flop
    always_comb begin
        tmr_d       = ((state_q == HOLD || state_q == LOAD) && state_d == state_q && !accept) ? tmr_q + 13'd1 : '0;
        cnt_d       = restart ? '0 : accept ? cnt_q + 9'd1 : cnt_q;
        sum_d       = restart ? '0 : accept ? sum_q + rx_data_i : sum_q;
        err_d       = restart ? ERR_NONE :
                      (state_q == LOAD && state_d == IDLE) ? ERR_TIMEOUT :
                      (state_q == CHECK && state_d == IDLE) ? ERR_CSUM : err_q;
        rx_ready_d  = state_d == LOAD;
        core_nrst_d = state_d == RUN;
        done_d      = state_d == RUN;
        busy_d      = state_d inside {HOLD, LOAD, CHECK};
        mem_we_d    = accept && !cnt_q[8];
        mem_addr_d  = mem_we_d ? cnt_q[7:0] : mem_addr_q;
        mem_wdata_d = mem_we_d ? rx_data_i : mem_wdata_q;
    end

    // datapath and output registers
    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            cnt_q       <= '0;
            tmr_q       <= '0;
            sum_q       <= '0;
            err_q       <= ERR_NONE;
            rx_ready_q  <= 1'b0;
            core_nrst_q <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            tmr_q       <= tmr_d;
            sum_q       <= sum_d;
            err_q       <= err_d;
            rx_ready_q  <= rx_ready_d;
            core_nrst_q <= core_nrst_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    up_tick_gen u_tick (
        .clk_i    (clk_i),
        .nrst_i   (nrst_i),
        .en_i     (tick_en_i && state_d == RUN),
        .period_i (tick_period_i),
        .int_o    (int_o)
    );

    assign rx_ready_o  = rx_ready_q;
    assign core_nrst_o = core_nrst_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_up_boot_ctrl.sv
// tb_up_boot_ctrl: directed table-driven bench for the up_core boot sequencer
module tb_up_boot_ctrl;

    typedef struct {
        logic [7:0] csum;
        int         stall;
        int         exp_writes;
        logic [1:0] exp_err;
        logic       exp_done;
    } load_vec_t;

    typedef struct {
        logic [15:0] period;
        int          lo;
        int          hi;
    } tick_vec_t;

    logic        clk = 0, nrst = 0, load_start = 0, rx_valid = 0, tick_en = 0;
    logic [7:0]  rx_data = 0;
    logic [15:0] tick_period = 16'd20;
    logic        rx_ready, core_nrst, mem_we, irq_n, busy, done;
    logic [7:0]  mem_addr, mem_wdata;
    logic [1:0]  err;

    int checks = 0, errors = 0;
    int wr_tot = 0, int_bad = 0;
    logic [7:0] log_a [0:2047];
    logic [7:0] log_d [0:2047];

    up_boot_ctrl dut (
        .clk_i         (clk),
        .nrst_i        (nrst),
        .load_start_i  (load_start),
        .rx_valid_i    (rx_valid),
        .rx_data_i     (rx_data),
        .rx_ready_o    (rx_ready),
        .core_nrst_o   (core_nrst),
        .mem_we_o      (mem_we),
        .mem_addr_o    (mem_addr),
        .mem_wdata_o   (mem_wdata),
        .tick_en_i     (tick_en),
        .tick_period_i (tick_period),
        .int_o         (irq_n),
        .busy_o        (busy),
        .done_o        (done),
        .err_o         (err)
    );

    always #5 clk = ~clk;

    // log every memory write and flag any interrupt outside RUN
    always @(negedge clk) begin
        if (mem_we && wr_tot < 2048) begin
            log_a[wr_tot] = mem_addr;
            log_d[wr_tot] = mem_wdata;
            wr_tot++;
        end
        if (!irq_n && !done) int_bad++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic start_load;
        load_start = 1;
        step;
        load_start = 0;
    endtask

    task automatic finish_load(input logic [7:0] csum, input int stall,
                               output int hold_n, output int ld_n, output int tail_n);
        hold_n = 0;
        ld_n   = 0;
        tail_n = 0;
        while (!rx_ready && hold_n < 100) begin step; hold_n++; end
        for (int k = 0; k <= 256; k++) begin
            int w = 0;
            rx_valid = 1;
            rx_data  = (k == 256) ? csum : k[7:0];
            while (!rx_ready && w < 100) begin step; w++; ld_n++; end
            step;
            ld_n++;
            if (k == stall) break;
        end
        rx_valid = 0;
        while (busy && tail_n < 6000) begin step; tail_n++; end
    endtask

    task automatic check_writes(input int base, input int exp_n);
        int bad = 0;
        for (int i = base; i < wr_tot; i++) begin
            int j = i - base;
            if (log_a[i] !== j[7:0] || log_d[i] !== j[7:0]) bad++;
        end
        chk("write_count", wr_tot - base, exp_n);
        chk("write_addr_data", bad, 0);
    endtask

    task automatic measure(output int lo, output int hi, output int lo2);
        int w = 0;
        lo = 0; hi = 0; lo2 = 0;
        while (irq_n && w < 200) begin step; w++; end
        while (!irq_n && lo < 200) begin step; lo++; end
        while (irq_n && hi < 200) begin step; hi++; end
        while (!irq_n && lo2 < 200) begin step; lo2++; end
    endtask

    initial begin
        load_vec_t lv [4];
        tick_vec_t tv [4];
        int hold_n, ld_n, tail_n, base, lo, hi, lo2, w;

        lv[0] = '{8'h80, -1, 256, 2'b00, 1'b1};
        lv[1] = '{8'h81, -1, 256, 2'b01, 1'b0};
        lv[2] = '{8'h80, 10, 11, 2'b10, 1'b0};
        lv[3] = '{8'h80, -1, 256, 2'b00, 1'b1};
        tv[0] = '{16'd20, 4, 16};
        tv[1] = '{16'd2, 4, 1};
        tv[2] = '{16'd0, 4, 1};
        tv[3] = '{16'd7, 4, 3};

        #12;
        chk("rst_rx_ready", rx_ready, 0);
        chk("rst_core_nrst", core_nrst, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_int", irq_n, 1);
        chk("rst_busy_done_err", {busy, done, err}, 0);
        @(negedge clk) nrst = 1;
        step; step;
        chk("idle_busy", busy, 0);
        chk("idle_core_nrst", core_nrst, 0);

        for (int r = 0; r < 4; r++) begin
            base = wr_tot;
            start_load;
            chk("load_err_clear", err, 2'b00);
            chk("load_busy", {busy, done, core_nrst}, 3'b100);
            finish_load(lv[r].csum, lv[r].stall, hold_n, ld_n, tail_n);
            chk("hold_cycles", hold_n, 16);
            chk("load_cycles", ld_n, (lv[r].stall < 0) ? 257 : lv[r].stall + 1);
            chk("tail_cycles", tail_n, (lv[r].stall < 0) ? 1 : 4096);
            check_writes(base, lv[r].exp_writes);
            chk("end_err", err, lv[r].exp_err);
            chk("end_done", done, lv[r].exp_done);
            chk("end_core_nrst", core_nrst, lv[r].exp_done);
            chk("end_busy", busy, 0);
        end

        for (int r = 0; r < 4; r++) begin
            tick_en = 0;
            tick_period = tv[r].period;
            step; step;
            chk("tick_off_int", irq_n, 1);
            tick_en = 1;
            measure(lo, hi, lo2);
            chk("tick_low", lo, tv[r].lo);
            chk("tick_high", hi, tv[r].hi);
            chk("tick_low2", lo2, tv[r].lo);
        end

        tick_period = 16'd20;
        w = 0;
        while (irq_n && w < 100) begin step; w++; end
        chk("pre_restart_int", irq_n, 0);
        base = wr_tot;
        start_load;
        chk("restart_core_nrst", core_nrst, 0);
        chk("restart_int", irq_n, 1);
        chk("restart_busy_done", {busy, done}, 2'b10);
        finish_load(8'h80, -1, hold_n, ld_n, tail_n);
        chk("restart_hold", hold_n, 16);
        check_writes(base, 256);
        chk("restart_done", {done, core_nrst, err}, 4'b1100);

        tick_en = 0;
        start_load;
        hold_n = 0;
        while (!rx_ready && hold_n < 100) begin step; hold_n++; end
        for (int k = 0; k < 100; k++) begin
            rx_valid = 1;
            rx_data  = k[7:0];
            step;
        end
        chk("pre_abort_we", {mem_we, mem_addr}, {1'b1, 8'd99});
        #2 nrst = 0;
        #1;
        chk("abort_rx_ready", rx_ready, 0);
        chk("abort_core_nrst", core_nrst, 0);
        chk("abort_mem_we", mem_we, 0);
        chk("abort_mem_addr", mem_addr, 0);
        chk("abort_mem_wdata", mem_wdata, 0);
        chk("abort_int", irq_n, 1);
        chk("abort_busy_done_err", {busy, done, err}, 0);
        rx_valid = 0;
        #20;
        @(negedge clk) nrst = 1;
        step; step;
        chk("post_abort_idle", {busy, rx_ready, done}, 0);
        chk("int_only_in_run", int_bad, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
